// File: rtl/usb_line_state.sv
// USB low-speed receive front end: pin sync, glitch filter, bit-phase recovery.
// Optional glitch filter enabled by defining USB_LINE_FILTER_EN.
package types;
  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10,
    SE1 = 2'b11
  } d_port_t;
endpackage

module usb_line_state
  import types::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FILTER_LEN   = 3
) (
  input  logic                            clk,
  input  logic                            reset_ni,
  input  logic                            dp_i,
  input  logic                            dn_i,
  output d_port_t                         line_state,
  output logic                            strobe,
  output logic [$clog2(CLKS_PER_BIT)-1:0] phase
);

  localparam int PW = $clog2(CLKS_PER_BIT);

  d_port_t dec;
  d_port_t s1;
  d_port_t s2;
  d_port_t ls_d;

  always_comb begin
    dec = J;
    unique case ({dp_i, dn_i})
      2'b00: dec = SE0;
      2'b01: dec = J;
      2'b10: dec = K;
      2'b11: dec = SE1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      s1 <= J;
      s2 <= J;
    end else begin
      s1 <= dec;
      s2 <= s1;
    end
  end

`ifdef USB_LINE_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  d_port_t       cand;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      cand <= J;
      cnt  <= CW'(FILTER_LEN);
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= CW'(1);
    end else if (cnt < CW'(FILTER_LEN)) begin
      cnt  <= cnt + 1'b1;
    end
  end

  // A length-1 filter commits on the same edge the candidate is captured.
  always_comb begin
    ls_d = line_state;
    if (FILTER_LEN == 1) begin
      if (s2 != cand) ls_d = s2;
    end else if (s2 == cand && cnt == CW'(FILTER_LEN - 1)) begin
      ls_d = cand;
    end
  end
`else
  always_comb begin
    ls_d = s2;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      line_state <= J;
    end else begin
      line_state <= ls_d;
    end
  end

  // Any line-state change resyncs the bit phase, even on a wrap edge.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      phase <= '0;
    end else if (ls_d != line_state) begin
      phase <= '0;
    end else if (phase == PW'(CLKS_PER_BIT - 1)) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign strobe = (phase == PW'(CLKS_PER_BIT / 2));

endmodule

// File: tb/tb_usb_line_state.sv
// Directed bench for usb_line_state: reset, idle, edges, glitches, SE0, jitter.
// Expected line-state schedule follows the pipeline latency of the build.
module tb_usb_line_state;
  import types::*;

  localparam int CPB = 16;
`ifdef USB_LINE_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic    clk = 1'b0;
  logic    reset_ni;
  logic    dp_i;
  logic    dn_i;
  d_port_t line_state;
  logic    strobe;
  logic [3:0] phase;

  int checks = 0;
  int errors = 0;
  d_port_t exp_ls;
  int ph;

  usb_line_state #(
    .CLKS_PER_BIT(CPB),
    .FILTER_LEN  (3)
  ) dut (
    .clk       (clk),
    .reset_ni  (reset_ni),
    .dp_i      (dp_i),
    .dn_i      (dn_i),
    .line_state(line_state),
    .strobe    (strobe),
    .phase     (phase)
  );

  always #21 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input d_port_t ls);
    @(posedge clk);
    #1;
    ph = (ls != exp_ls) ? 0 : (ph + 1) % CPB;
    exp_ls = ls;
    chk("line_state", int'(line_state), int'(ls));
    chk("phase", int'(phase), ph);
    chk("strobe", int'(strobe), int'(ph == CPB / 2));
  endtask

  task automatic hold(input logic [1:0] p, input int n);
    d_port_t old;
    d_port_t nw;
    old = exp_ls;
    nw = d_port_t'(p);
    {dp_i, dn_i} = p;
    for (int k = 1; k <= n; k++) tick(k >= LAT ? nw : old);
  endtask

  int jit[8] = '{16, 14, 18, 17, 15, 16, 18, 14};

  initial begin
    reset_ni = 1'b0;
    {dp_i, dn_i} = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    exp_ls = J;
    ph = 0;
    chk("rst_line_state", int'(line_state), int'(J));
    chk("rst_phase", int'(phase), 0);
    chk("rst_strobe", int'(strobe), 0);
    reset_ni = 1'b1;

    hold(2'b01, 100);
    hold(2'b10, 40);
    hold(2'b01, 30);

    {dp_i, dn_i} = 2'b00;
    tick(J);
    tick(J);
    {dp_i, dn_i} = 2'b01;
`ifdef USB_LINE_FILTER_EN
    for (int k = 0; k < 10; k++) tick(J);
`else
    tick(SE0);
    tick(SE0);
    for (int k = 0; k < 8; k++) tick(J);
`endif

    hold(2'b01, 240);
    hold(2'b00, 58);
    hold(2'b01, 30);

    hold(2'b11, 10);
    hold(2'b01, 10);

    for (int i = 0; i < 8; i++) hold(i[0] ? 2'b01 : 2'b10, jit[i]);
    hold(2'b01, 20);

    hold(2'b10, LAT + 11);
    chk("pre_rst_phase", int'(phase), 11);
    reset_ni = 1'b0;
    tick(J);
    reset_ni = 1'b1;
    hold(2'b10, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
